// File: rtl/facache.sv
// facache: four-entry fully associative word cache with LRU replacement and eviction port.
// Define FACACHE_DEBUG_EN to trace fills and evictions with the level ID.
module facache #(
   parameter int ID = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] raddr,
   input  logic        re,
   input  logic [15:0] waddr,
   input  logic [15:0] wdata,
   input  logic        we,
   output logic [15:0] rdata,
   output logic        hit,
   output logic [15:0] ev_addr,
   output logic [15:0] ev_data,
   output logic        ev_valid
);

   logic [3:0]  valid_r;
   logic [15:0] addr_r [4];
   logic [15:0] data_r [4];
   logic [1:0]  rank_r [4];

   logic [3:0]  rhit_vec_s;
   logic        rhit_s;
   logic [1:0]  ridx_s;
   logic [3:0]  wmatch_vec_s;
   logic        wmatch_s;
   logic [1:0]  widx_s;
   logic        free_s;
   logic [1:0]  free_idx_s;
   logic [3:0]  victim_vec_s;
   logic [1:0]  victim_idx_s;
   logic [1:0]  fill_idx_s;
   logic        evict_s;
   logic [1:0]  rank_mid_s [4];
   logic [1:0]  rank_nxt_s [4];

   function automatic logic [1:0] lowest_idx(input logic [3:0] vec);
      logic [1:0] idx;
      casez (vec)
         4'b???1: idx = 2'd0;
         4'b??10: idx = 2'd1;
         4'b?100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Making a slot MRU lifts it to 3 and shifts everything above its old rank down one.
   function automatic logic [1:0] touch_rank(input logic [1:0] rank, input logic [1:0] old_rank,
                                             input logic is_slot);
      logic [1:0] res;
      if (is_slot) begin
         res = 2'd3;
      end else if (rank > old_rank) begin
         res = rank - 2'd1;
      end else begin
         res = rank;
      end
      return res;
   endfunction

   // Tag compare for the lookup and fill ports against the pre-fill contents.
   always_comb begin
      rhit_vec_s   = 4'b0000;
      wmatch_vec_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         rhit_vec_s[i]   = re & valid_r[i] & (addr_r[i] == raddr);
         wmatch_vec_s[i] = valid_r[i] & (addr_r[i] == waddr);
      end
      rhit_s     = |rhit_vec_s;
      ridx_s     = lowest_idx(rhit_vec_s);
      wmatch_s   = |wmatch_vec_s;
      widx_s     = lowest_idx(wmatch_vec_s);
      free_s     = ~(&valid_r);
      free_idx_s = lowest_idx(~valid_r);
   end

   // Lookup touch is applied first; replacement picks its victim from those ranks.
   always_comb begin
      victim_vec_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (rhit_s) begin
            rank_mid_s[i] = touch_rank(rank_r[i], rank_r[ridx_s], (ridx_s == 2'(i)));
         end else begin
            rank_mid_s[i] = rank_r[i];
         end
         victim_vec_s[i] = (rank_mid_s[i] == 2'd0);
      end
      victim_idx_s = lowest_idx(victim_vec_s);
   end

   // Fill slot selection: in-place update, then lowest free slot, then LRU victim.
   always_comb begin
      if (wmatch_s) begin
         fill_idx_s = widx_s;
      end else if (free_s) begin
         fill_idx_s = free_idx_s;
      end else begin
         fill_idx_s = victim_idx_s;
      end
      evict_s = we & ~wmatch_s & ~free_s;
   end

   // Fill touch layered on top of the lookup touch.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         if (we) begin
            rank_nxt_s[i] = touch_rank(rank_mid_s[i], rank_mid_s[fill_idx_s], (fill_idx_s == 2'(i)));
         end else begin
            rank_nxt_s[i] = rank_mid_s[i];
         end
      end
   end

   // Slot storage and recency ranks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            addr_r[i] <= 16'h0000;
            data_r[i] <= 16'h0000;
            rank_r[i] <= 2'(i);
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            rank_r[i] <= rank_nxt_s[i];
         end
         if (we) begin
            valid_r[fill_idx_s] <= 1'b1;
            addr_r[fill_idx_s]  <= waddr;
            data_r[fill_idx_s]  <= wdata;
         end else begin
            valid_r <= valid_r;
         end
      end
   end

   // Registered lookup result and one-cycle eviction report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit      <= 1'b0;
         rdata    <= 16'h0000;
         ev_valid <= 1'b0;
         ev_addr  <= 16'h0000;
         ev_data  <= 16'h0000;
      end else begin
         hit      <= rhit_s;
         rdata    <= rhit_s ? data_r[ridx_s] : 16'h0000;
         ev_valid <= evict_s;
         ev_addr  <= evict_s ? addr_r[victim_idx_s] : 16'h0000;
         ev_data  <= evict_s ? data_r[victim_idx_s] : 16'h0000;
      end
   end

`ifdef FACACHE_DEBUG_EN
   // Trace of fills and evictions at the fill edge.
   always_ff @(posedge clk) begin
      if (!rst && we) begin
         $display("facache L%0d fill addr=%h data=%h", ID, waddr, wdata);
         if (evict_s) begin
            $display("facache L%0d evict addr=%h data=%h", ID, addr_r[victim_idx_s],
                     data_r[victim_idx_s]);
         end else begin
         end
      end else begin
      end
   end
`else
`endif

endmodule

// File: tb/tb_facache.sv
// Directed bench for facache: recency-list model checked every cycle plus literal test-plan checks.
module tb_facache;
   logic        clk;
   logic        rst;
   logic [15:0] raddr;
   logic        re;
   logic [15:0] waddr;
   logic [15:0] wdata;
   logic        we;
   logic [15:0] rdata;
   logic        hit;
   logic [15:0] ev_addr;
   logic [15:0] ev_data;
   logic        ev_valid;

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 0;

   // model: slot contents plus an LRU-first list of slot indices
   bit          m_valid [4];
   logic [15:0] m_addr  [4];
   logic [15:0] m_data  [4];
   int          order[$];

   logic        nx_hit, nx_ev;
   logic [15:0] nx_rdata, nx_ev_addr, nx_ev_data;
   logic        exp_hit, exp_ev;
   logic [15:0] exp_rdata, exp_ev_addr, exp_ev_data;

   facache #(.ID(1)) dut (
      .clk(clk), .rst(rst), .raddr(raddr), .re(re), .waddr(waddr), .wdata(wdata), .we(we),
      .rdata(rdata), .hit(hit), .ev_addr(ev_addr), .ev_data(ev_data), .ev_valid(ev_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0;
         m_addr[i]  = 16'h0;
         m_data[i]  = 16'h0;
      end
      order      = {0, 1, 2, 3};
      nx_hit     = 1'b0;
      nx_rdata   = 16'h0;
      nx_ev      = 1'b0;
      nx_ev_addr = 16'h0;
      nx_ev_data = 16'h0;
   endtask

   task automatic make_mru(input int s);
      for (int k = 0; k < order.size(); k++) begin
         if (order[k] == s) begin
            order.delete(k);
            break;
         end
      end
      order.push_back(s);
   endtask

   task automatic model_step(input logic r, input logic [15:0] ra, input logic w,
                             input logic [15:0] wa, input logic [15:0] wd);
      int li, wi;
      li = -1;
      wi = -1;
      nx_hit = 1'b0; nx_rdata = 16'h0; nx_ev = 1'b0; nx_ev_addr = 16'h0; nx_ev_data = 16'h0;
      if (r) begin
         for (int i = 0; i < 4; i++) if (m_valid[i] && m_addr[i] == ra) li = i;
      end
      if (li >= 0) begin
         nx_hit   = 1'b1;
         nx_rdata = m_data[li];
         make_mru(li);
      end
      if (w) begin
         for (int i = 0; i < 4; i++) if (m_valid[i] && m_addr[i] == wa) wi = i;
         if (wi < 0) begin
            for (int i = 3; i >= 0; i--) if (!m_valid[i]) wi = i;
         end
         if (wi < 0) begin
            wi         = order[0];
            nx_ev      = 1'b1;
            nx_ev_addr = m_addr[wi];
            nx_ev_data = m_data[wi];
         end
         m_valid[wi] = 1'b1;
         m_addr[wi]  = wa;
         m_data[wi]  = wd;
         make_mru(wi);
      end
   endtask

   // drive one cycle of stimulus (takes effect at the next rising edge)
   task automatic cyc(input logic r, input logic [15:0] ra, input logic w,
                      input logic [15:0] wa, input logic [15:0] wd);
      @(negedge clk);
      #1;
      re = r; raddr = ra; we = w; waddr = wa; wdata = wd;
      model_step(r, ra, w, wa, wd);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_hit <= 1'b0; exp_rdata <= 16'h0; exp_ev <= 1'b0;
         exp_ev_addr <= 16'h0; exp_ev_data <= 16'h0;
      end else begin
         exp_hit <= nx_hit; exp_rdata <= nx_rdata; exp_ev <= nx_ev;
         exp_ev_addr <= nx_ev_addr; exp_ev_data <= nx_ev_data;
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("cyc_hit", {15'h0, hit}, {15'h0, exp_hit});
         chk("cyc_rdata", rdata, exp_rdata);
         chk("cyc_ev_valid", {15'h0, ev_valid}, {15'h0, exp_ev});
         if (exp_ev) begin
            chk("cyc_ev_addr", ev_addr, exp_ev_addr);
            chk("cyc_ev_data", ev_data, exp_ev_data);
         end
      end
   end

   initial begin
      rst = 1'b1; re = 1'b0; we = 1'b0; raddr = 16'h0; waddr = 16'h0; wdata = 16'h0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      chk("reset_hit", {15'h0, hit}, 16'h0);
      chk("reset_ev_addr", ev_addr, 16'h0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      checking = 1'b1;

      cyc(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
      after_edge();
      chk("empty_hit", {15'h0, hit}, 16'h0);
      chk("empty_rdata", rdata, 16'h0);
      chk("empty_ev", {15'h0, ev_valid}, 16'h0);

      cyc(1'b0, 16'h0, 1'b1, 16'h0010, 16'hAAAA);
      cyc(1'b0, 16'h0, 1'b1, 16'h0020, 16'hBBBB);
      cyc(1'b0, 16'h0, 1'b1, 16'h0030, 16'hCCCC);
      cyc(1'b0, 16'h0, 1'b1, 16'h0040, 16'hDDDD);
      cyc(1'b1, 16'h0030, 1'b0, 16'h0, 16'h0);
      after_edge();
      chk("hit30", {15'h0, hit}, 16'h1);
      chk("rdata30", rdata, 16'hCCCC);

      cyc(1'b0, 16'h0, 1'b1, 16'h0050, 16'h5555);
      after_edge();
      chk("ev50_valid", {15'h0, ev_valid}, 16'h1);
      chk("ev50_addr", ev_addr, 16'h0010);
      chk("ev50_data", ev_data, 16'hAAAA);
      cyc(1'b0, 16'h0, 1'b1, 16'h0060, 16'h6666);
      after_edge();
      chk("ev60_addr", ev_addr, 16'h0020);
      chk("ev60_data", ev_data, 16'hBBBB);

      cyc(1'b0, 16'h0, 1'b1, 16'h0040, 16'h1234);
      after_edge();
      chk("upd40_ev", {15'h0, ev_valid}, 16'h0);
      cyc(1'b1, 16'h0040, 1'b0, 16'h0, 16'h0);
      after_edge();
      chk("upd40_rdata", rdata, 16'h1234);

      cyc(1'b1, 16'h0070, 1'b1, 16'h0070, 16'h7777);
      after_edge();
      chk("same70_hit", {15'h0, hit}, 16'h0);
      chk("same70_ev_addr", ev_addr, 16'h0030);
      cyc(1'b1, 16'h0070, 1'b0, 16'h0, 16'h0);
      after_edge();
      chk("next70_hit", {15'h0, hit}, 16'h1);
      chk("next70_rdata", rdata, 16'h7777);

      // back-to-back lookups, an evicted address, and a lookup+fill on the same slot
      cyc(1'b1, 16'h0050, 1'b0, 16'h0, 16'h0);
      cyc(1'b1, 16'h0060, 1'b0, 16'h0, 16'h0);
      cyc(1'b1, 16'h0030, 1'b0, 16'h0, 16'h0);
      cyc(1'b1, 16'h0050, 1'b1, 16'h0050, 16'h5A5A);
      cyc(1'b0, 16'h0, 1'b1, 16'h0080, 16'h8888);
      cyc(1'b0, 16'h0, 1'b1, 16'h0090, 16'h9999);
      cyc(1'b1, 16'h0050, 1'b0, 16'h0, 16'h0);
      cyc(1'b1, 16'h0080, 1'b0, 16'h0, 16'h0);
      after_edge();
      chk("hit80", {15'h0, hit}, 16'h1);
      chk("rdata80", rdata, 16'h8888);

      // asynchronous reset between edges while hit is high
      rst = 1'b1;
      re = 1'b0;
      we = 1'b0;
      #1;
      chk("arst_hit", {15'h0, hit}, 16'h0);
      chk("arst_rdata", rdata, 16'h0);
      chk("arst_ev", {15'h0, ev_valid}, 16'h0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;

      cyc(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
      cyc(1'b1, 16'h0050, 1'b0, 16'h0, 16'h0);
      cyc(1'b1, 16'h0070, 1'b0, 16'h0, 16'h0);
      cyc(1'b1, 16'h0080, 1'b0, 16'h0, 16'h0);
      after_edge();
      chk("post_rst_hit", {15'h0, hit}, 16'h0);
      cyc(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      cyc(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      @(posedge clk);
      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
